// File: rtl/lcd_cmd_queue.sv
// lcd_cmd_queue: host command FIFO feeding an LCD controller with busy/frame-done pacing.
// Define LCD_CMD_CHECK_EN to reject opcodes 12..15 with a one-cycle cmd_err pulse.
module lcd_cmd_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               host_cmd,
    input  logic                     host_valid,
    output logic                     host_ready,
    output logic [3:0]               cmd,
    output logic                     cmd_valid,
    input  logic                     busy,
    input  logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               frame_cnt,
    output logic                     cmd_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [2:0] {IDLE, ISSUE, HOLD, WAIT_FRAME, WAIT} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [3:0]     cmd_q, cmd_d;
    logic           cmd_valid_q, cmd_valid_d;
    logic           cmd_err_q, cmd_err_d;
    logic [7:0]     frame_cnt_q, frame_cnt_d;
    logic           done_q, done_d;
    logic [3:0]     mem_q [DEPTH];
    logic           push, bad_cmd, wr_en, pop, done_rise;

    assign host_ready = level_q < LW'(DEPTH);
    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign fifo_level = level_q;
    assign frame_cnt  = frame_cnt_q;
    assign cmd_err    = cmd_err_q;

    always_comb begin
        push = host_valid && host_ready;
`ifdef LCD_CMD_CHECK_EN
        bad_cmd = host_cmd >= 4'd12;
`else
        bad_cmd = 1'b0;
`endif
        wr_en       = push && !bad_cmd;
        pop         = state_q == IDLE && level_q != '0 && !busy;
        done_rise   = done && !done_q;
        wr_ptr_d    = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d     = level_q + LW'(wr_en) - LW'(pop);
        cmd_d       = pop ? mem_q[rd_ptr_q] : cmd_q;
        cmd_valid_d = pop;
        cmd_err_d   = push && bad_cmd;
        frame_cnt_d = done_rise ? frame_cnt_q + 8'd1 : frame_cnt_q;
        done_d      = done;
        // HOLD spends one cycle ignoring busy while the controller raises it
        unique case (state_q)
            IDLE:       state_d = pop ? ISSUE : IDLE;
            ISSUE:      state_d = HOLD;
            HOLD:       state_d = cmd_q == 4'd0 ? WAIT_FRAME : WAIT;
            WAIT_FRAME: state_d = done_rise ? WAIT : WAIT_FRAME;
            WAIT:       state_d = busy ? WAIT : IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cmd_q       <= 4'd0;
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_err_q   <= cmd_err_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= host_cmd;
    end
endmodule
